// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One transaction at a time: IDLE -> ACCESS (MEM_LATENCY+1 cycles) -> RESP (done pulse).
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } ArbState;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } PortSel;

  ArbState             r_state;
  ArbState             w_stateNext;
  PortSel              r_lastGrant;
  PortSel              r_grant;
  PortSel              w_grantPort;
  logic                w_grantValid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_capture;

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    w_grantValid = if_req | d_req;
    w_grantPort  = PORT_IF;
    if (if_req && d_req) begin
      w_grantPort = (r_lastGrant == PORT_IF) ? PORT_D : PORT_IF;
    end else if (d_req) begin
      w_grantPort = PORT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    if_done     = 1'b0;
    d_done      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grantValid) begin
          w_stateNext = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        // The strobe fires only in the first ACCESS cycle; the rest just wait out latency.
        if (r_cnt == '0) begin
          mem_en = 1'b1;
          mem_we = r_we;
        end
        if (r_cnt == LAST_CNT) begin
          w_stateNext = RESP;
        end
      end
      RESP: begin
        busy        = 1'b1;
        if_done     = (r_grant == PORT_IF);
        d_done      = (r_grant == PORT_D);
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Request latch, latency counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= PORT_D;
      r_grant     <= PORT_IF;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_cnt       <= '0;
      r_capture   <= '0;
    end else begin
      if (r_state == IDLE && w_grantValid) begin
        r_grant     <= w_grantPort;
        r_lastGrant <= w_grantPort;
        r_cnt       <= '0;
        if (w_grantPort == PORT_IF) begin
          r_addr  <= if_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
          r_wstrb <= '1;
        end else begin
          r_addr  <= d_addr;
          r_we    <= d_we;
          r_wdata <= d_wdata;
          r_wstrb <= d_we ? d_wstrb : {STRB_W{1'b1}};
        end
      end
      if (r_state == ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == LAST_CNT && !r_we) begin
          r_capture <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign if_rdata  = r_capture;
  assign d_rdata   = r_capture;

endmodule
